// File: rtl/uart_tx_reporter_pkg.sv
// Shared definitions for the UART text reporter: source-mode and FSM encodings,
// the ASCII characters used in report lines, per-mode line lengths and the
// latched report snapshot.
package uart_tx_reporter_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned BIN_W  = 9;
    localparam int unsigned BCD_W  = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_WATCH = 2'd0,
        MODE_SW    = 2'd1,
        MODE_SR04  = 2'd2,
        MODE_DHT   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_SPACE  = 8'h20;
    localparam logic [7:0] ASCII_COLON  = 8'h3A;
    localparam logic [7:0] ASCII_DOT    = 8'h2E;
    localparam logic [7:0] ASCII_DIGIT0 = 8'h30;
    localparam logic [7:0] ASCII_W      = 8'h57;
    localparam logic [7:0] ASCII_S      = 8'h53;
    localparam logic [7:0] ASCII_D      = 8'h44;
    localparam logic [7:0] ASCII_T      = 8'h54;
    localparam logic [7:0] ASCII_H      = 8'h48;
    localparam logic [7:0] ASCII_C_LOW  = 8'h63;
    localparam logic [7:0] ASCII_M_LOW  = 8'h6D;

    localparam logic [IDX_W-1:0] LEN_WATCH = 4'd12;
    localparam logic [IDX_W-1:0] LEN_SW    = 4'd12;
    localparam logic [IDX_W-1:0] LEN_SR04  = 4'd10;
    localparam logic [IDX_W-1:0] LEN_DHT   = 4'd11;

    // Values captured at LATCH; the whole message is built from these.
    typedef struct packed {
        mode_e       mode;
        logic [4:0]  w_hour;
        logic [5:0]  w_min;
        logic [5:0]  w_sec;
        logic [5:0]  s_min;
        logic [5:0]  s_sec;
        logic [6:0]  s_cc;
        logic [8:0]  dist_cm;
        logic [7:0]  temp;
        logic [7:0]  humi;
    } snap_t;

    function automatic logic [IDX_W-1:0] msg_len(input mode_e m);
        case (m)
            MODE_WATCH: return LEN_WATCH;
            MODE_SW:    return LEN_SW;
            MODE_SR04:  return LEN_SR04;
            default:    return LEN_DHT;
        endcase
    endfunction

    // Two-digit fields clamp to 99.
    function automatic logic [BIN_W-1:0] sat99(input logic [BIN_W-1:0] v);
        return (v > BIN_W'(99)) ? BIN_W'(99) : v;
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [BCD_W-1:0] bcd);
        return ASCII_DIGIT0 + 8'(bcd);
    endfunction

endpackage

// File: rtl/reporter_bin2bcd.sv
// Combinational 9-bit binary to 3-digit BCD converter (double-dabble).
// Ports: i_bin - binary value 0..511; o_hund/o_tens/o_ones - BCD digits.
module reporter_bin2bcd
    import uart_tx_reporter_pkg::*;
(
    input  logic [BIN_W-1:0] i_bin,
    output logic [BCD_W-1:0] o_hund,
    output logic [BCD_W-1:0] o_tens,
    output logic [BCD_W-1:0] o_ones
);

    localparam int unsigned SR_W = BIN_W + 3 * BCD_W;

    logic [SR_W-1:0] w_sr;

    // Add-3 on any digit >= 5, then shift; repeated once per input bit.
    always_comb begin
        w_sr = {12'h000, i_bin};
        for (int unsigned i = 0; i < BIN_W; i++) begin
            if (w_sr[BIN_W+3:BIN_W] >= 4'd5)
                w_sr[BIN_W+3:BIN_W] = w_sr[BIN_W+3:BIN_W] + 4'd3;
            if (w_sr[BIN_W+7:BIN_W+4] >= 4'd5)
                w_sr[BIN_W+7:BIN_W+4] = w_sr[BIN_W+7:BIN_W+4] + 4'd3;
            if (w_sr[BIN_W+11:BIN_W+8] >= 4'd5)
                w_sr[BIN_W+11:BIN_W+8] = w_sr[BIN_W+11:BIN_W+8] + 4'd3;
            w_sr = w_sr << 1;
        end
    end

    assign o_hund = w_sr[BIN_W+11:BIN_W+8];
    assign o_tens = w_sr[BIN_W+7:BIN_W+4];
    assign o_ones = w_sr[BIN_W+3:BIN_W];

endmodule

// File: rtl/uart_tx_reporter.sv
// Formats the selected display source (watch, stopwatch, SR04, DHT11) as an
// ASCII line ending in CR LF and streams it byte-by-byte into uart_tx.
// Ports: clk/rst (async active-low); report_req, auto_en - triggers; mode and
// source fields - data to report; tx_busy/tx_done - uart_tx handshake;
// tx_start/tx_data - byte launch; rep_busy/rep_done - report status.
module uart_tx_reporter
    import uart_tx_reporter_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned AUTO_MS = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              report_req,
    input  logic              auto_en,
    input  logic [MODE_W-1:0] mode,
    input  logic [4:0]        w_hour,
    input  logic [5:0]        w_min,
    input  logic [5:0]        w_sec,
    input  logic [5:0]        s_min,
    input  logic [5:0]        s_sec,
    input  logic [6:0]        s_cc,
    input  logic [8:0]        dist_cm,
    input  logic [7:0]        temp,
    input  logic [7:0]        humi,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              rep_busy,
    output logic              rep_done
);

    localparam int unsigned AUTO_CYC = CLK_HZ / 1000 * AUTO_MS;
    localparam int unsigned AUTO_W   = (AUTO_CYC > 1) ? $clog2(AUTO_CYC) : 1;

    state_e              r_state;
    snap_t               r_snap;
    logic [IDX_W-1:0]    r_idx;
    logic                r_pending;
    logic [AUTO_W-1:0]   r_auto_cnt;

    logic                w_auto_pulse;
    logic                w_trig;
    logic                w_last;
    logic [BIN_W-1:0]    w_field;
    logic [BIN_W-1:0]    w_bin;
    logic [BCD_W-1:0]    w_bcd_hund;
    logic [BCD_W-1:0]    w_bcd_tens;
    logic [BCD_W-1:0]    w_bcd_ones;
    logic [7:0]          w_dh;
    logic [7:0]          w_dt;
    logic [7:0]          w_do;
    logic [7:0]          w_char;

    // Periodic auto-report timer; held at zero while disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_auto_cnt <= '0;
        end else if (!auto_en) begin
            r_auto_cnt <= '0;
        end else if (r_auto_cnt == AUTO_W'(AUTO_CYC - 1)) begin
            r_auto_cnt <= '0;
        end else begin
            r_auto_cnt <= r_auto_cnt + AUTO_W'(1);
        end
    end

    assign w_auto_pulse = auto_en && (r_auto_cnt == AUTO_W'(AUTO_CYC - 1));
    assign w_trig       = report_req | w_auto_pulse;
    assign w_last       = (r_idx == msg_len(r_snap.mode) - 4'd1);

    // Pick the numeric field that feeds the current character position.
    always_comb begin
        w_field = '0;
        case (r_snap.mode)
            MODE_WATCH: begin
                if (r_idx < 4'd4)      w_field = BIN_W'(r_snap.w_hour);
                else if (r_idx < 4'd7) w_field = BIN_W'(r_snap.w_min);
                else                   w_field = BIN_W'(r_snap.w_sec);
            end
            MODE_SW: begin
                if (r_idx < 4'd4)      w_field = BIN_W'(r_snap.s_min);
                else if (r_idx < 4'd7) w_field = BIN_W'(r_snap.s_sec);
                else                   w_field = BIN_W'(r_snap.s_cc);
            end
            MODE_SR04: w_field = r_snap.dist_cm;
            default: begin
                if (r_idx < 4'd5)      w_field = BIN_W'(r_snap.temp);
                else                   w_field = BIN_W'(r_snap.humi);
            end
        endcase
    end

    // Distance keeps all three digits; every other field is two-digit.
    assign w_bin = (r_snap.mode == MODE_SR04) ? w_field : sat99(w_field);

    reporter_bin2bcd u_bin2bcd (
        .i_bin  (w_bin),
        .o_hund (w_bcd_hund),
        .o_tens (w_bcd_tens),
        .o_ones (w_bcd_ones)
    );

    assign w_dh = ascii_digit(w_bcd_hund);
    assign w_dt = ascii_digit(w_bcd_tens);
    assign w_do = ascii_digit(w_bcd_ones);

    // Character at (latched mode, index).
    always_comb begin
        w_char = ASCII_SPACE;
        case (r_snap.mode)
            MODE_WATCH, MODE_SW: begin
                case (r_idx)
                    4'd0:    w_char = (r_snap.mode == MODE_WATCH) ? ASCII_W : ASCII_S;
                    4'd2, 4'd5, 4'd8: w_char = w_dt;
                    4'd3, 4'd6, 4'd9: w_char = w_do;
                    4'd4:    w_char = ASCII_COLON;
                    4'd7:    w_char = (r_snap.mode == MODE_WATCH) ? ASCII_COLON : ASCII_DOT;
                    4'd10:   w_char = ASCII_CR;
                    4'd11:   w_char = ASCII_LF;
                    default: w_char = ASCII_SPACE;
                endcase
            end
            MODE_SR04: begin
                case (r_idx)
                    4'd0:    w_char = ASCII_D;
                    4'd2:    w_char = w_dh;
                    4'd3:    w_char = w_dt;
                    4'd4:    w_char = w_do;
                    4'd6:    w_char = ASCII_C_LOW;
                    4'd7:    w_char = ASCII_M_LOW;
                    4'd8:    w_char = ASCII_CR;
                    4'd9:    w_char = ASCII_LF;
                    default: w_char = ASCII_SPACE;
                endcase
            end
            default: begin
                case (r_idx)
                    4'd0:       w_char = ASCII_T;
                    4'd2, 4'd7: w_char = w_dt;
                    4'd3, 4'd8: w_char = w_do;
                    4'd5:       w_char = ASCII_H;
                    4'd9:       w_char = ASCII_CR;
                    4'd10:      w_char = ASCII_LF;
                    default:    w_char = ASCII_SPACE;
                endcase
            end
        endcase
    end

    // Report sequencer with registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_snap    <= '0;
            r_idx     <= '0;
            r_pending <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            rep_busy  <= 1'b0;
            rep_done  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            rep_done <= 1'b0;
            // Requests arriving mid-report coalesce into a single follow-up.
            if (w_trig && (r_state != ST_IDLE))
                r_pending <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_trig || r_pending) begin
                        r_pending <= 1'b0;
                        r_state   <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    r_snap   <= '{mode: mode_e'(mode), w_hour: w_hour, w_min: w_min,
                                  w_sec: w_sec, s_min: s_min, s_sec: s_sec, s_cc: s_cc,
                                  dist_cm: dist_cm, temp: temp, humi: humi};
                    r_idx    <= '0;
                    rep_busy <= 1'b1;
                    r_state  <= ST_SEND;
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= w_char;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (w_last) begin
                            rep_done <= 1'b1;
                            rep_busy <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= ST_SEND;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_reporter.sv
// Directed self-checking bench for uart_tx_reporter with a simple uart_tx
// model (busy for 10 cycles per byte, then a one-cycle tx_done).
module tb_uart_tx_reporter;

    logic       clk = 1'b0;
    logic       rst;
    logic       report_req;
    logic       auto_en;
    logic [1:0] mode;
    logic [4:0] w_hour;
    logic [5:0] w_min;
    logic [5:0] w_sec;
    logic [5:0] s_min;
    logic [5:0] s_sec;
    logic [6:0] s_cc;
    logic [8:0] dist_cm;
    logic [7:0] temp;
    logic [7:0] humi;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       rep_busy;
    logic       rep_done;

    int unsigned cyc      = 0;
    int unsigned n_start  = 0;
    int unsigned n_done   = 0;
    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    logic [7:0]  q[$];
    logic        m_busy   = 1'b0;
    int unsigned m_cnt    = 0;

    uart_tx_reporter #(.CLK_HZ(1000), .AUTO_MS(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .report_req (report_req),
        .auto_en    (auto_en),
        .mode       (mode),
        .w_hour     (w_hour),
        .w_min      (w_min),
        .w_sec      (w_sec),
        .s_min      (s_min),
        .s_sec      (s_sec),
        .s_cc       (s_cc),
        .dist_cm    (dist_cm),
        .temp       (temp),
        .humi       (humi),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .rep_busy   (rep_busy),
        .rep_done   (rep_done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Byte monitor plus uart_tx model, evaluated on the falling edge.
    initial begin
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                q.push_back(tx_data);
                n_start++;
            end
            if (rep_done) n_done++;
            tx_done = 1'b0;
            if (!rst) begin
                m_busy = 1'b0;
                m_cnt  = 0;
            end else if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy  = 1'b0;
                    tx_done = 1'b1;
                end
            end else if (tx_start) begin
                m_busy = 1'b1;
                m_cnt  = 10;
            end
            tx_busy = m_busy;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req(output int unsigned t_trig);
        @(negedge clk);
        report_req = 1'b1;
        t_trig     = cyc + 1;
        @(negedge clk);
        report_req = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int unsigned exp_cyc);
        int unsigned k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tx_start && k < 300);
        check(tag, 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic wait_done(input string tag, input int unsigned target, input int unsigned budget);
        int unsigned k = 0;
        while (n_done < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(n_done), 32'(target));
    endtask

    task automatic pop_byte(output logic [31:0] b);
        if (q.size() == 0) b = 32'hFFFF_FFFF;
        else               b = 32'(q.pop_front());
    endtask

    task automatic check_msg(input string tag, input string s);
        logic [31:0] b;
        for (int i = 0; i < s.len(); i++) begin
            pop_byte(b);
            check(tag, b, 32'(s[i]));
        end
        pop_byte(b);
        check({tag, "_cr"}, b, 32'h0D);
        pop_byte(b);
        check({tag, "_lf"}, b, 32'h0A);
    endtask

    task automatic send_and_check(input string tag, input string s);
        int unsigned t;
        int unsigned n0 = n_done;
        pulse_req(t);
        wait_done({tag, "_done"}, n0 + 1, 400);
        idle(5);
        check_msg(tag, s);
    endtask

    initial begin
        int unsigned t;
        int unsigned n0s;
        int unsigned n0d;
        int unsigned seen;
        int unsigned k;

        rst = 1'b0; report_req = 1'b0; auto_en = 1'b0; mode = 2'd0;
        w_hour = 5'd7; w_min = 6'd5; w_sec = 6'd42;
        s_min = 6'd0; s_sec = 6'd0; s_cc = 7'd0;
        dist_cm = 9'd0; temp = 8'd0; humi = 8'd0;
        idle(3);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data",  32'(tx_data),  32'd0);
        check("rst_rep_busy", 32'(rep_busy), 32'd0);
        check("rst_rep_done", 32'(rep_done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(3);

        // Watch line, first-byte latency and pulse counts.
        n0s = n_start; n0d = n_done;
        pulse_req(t);
        wait_start("watch_latency", t + 2);
        check("watch_busy", 32'(rep_busy), 32'd1);
        wait_done("watch_done", n0d + 1, 400);
        idle(20);
        check("watch_starts", 32'(n_start - n0s), 32'd12);
        check("watch_dones",  32'(n_done - n0d),  32'd1);
        check("watch_idle",   32'(rep_busy),      32'd0);
        check_msg("watch_msg", "W 07:05:42");
        check("watch_q", 32'(q.size()), 32'd0);

        // Distance with leading zeros, then maximum with mid-message changes.
        mode = 2'd2; dist_cm = 9'd9;
        send_and_check("sr04_9", "D 009 cm");
        dist_cm = 9'd511;
        n0d = n_done;
        pulse_req(t);
        idle(40);
        dist_cm = 9'd123;
        mode    = 2'd3;
        wait_done("sr04_511_done", n0d + 1, 400);
        idle(5);
        check_msg("sr04_511", "D 511 cm");

        // Saturating two-digit fields.
        mode = 2'd3; temp = 8'd200; humi = 8'd45;
        send_and_check("dht_sat", "T 99 H 45");
        mode = 2'd1; s_min = 6'd3; s_sec = 6'd59; s_cc = 7'd120;
        n0d = n_done;
        pulse_req(t);
        idle(30);
        mode = 2'd0; s_cc = 7'd5;
        wait_done("sw_done", n0d + 1, 400);
        idle(5);
        check_msg("sw_sat", "S 03:59.99");

        // Three requests during a message coalesce into one follow-up.
        mode = 2'd2; dist_cm = 9'd77;
        n0d = n_done;
        pulse_req(t);
        idle(10);
        repeat (3) begin
            pulse_req(t);
            idle(5);
        end
        wait_done("coal_done", n0d + 2, 800);
        idle(300);
        check("coal_count", 32'(n_done - n0d), 32'd2);
        check_msg("coal_msg1", "D 077 cm");
        check_msg("coal_msg2", "D 077 cm");
        check("coal_q", 32'(q.size()), 32'd0);

        // Auto-report: first report 5 timer cycles after enable, then back-to-back.
        mode = 2'd0;
        n0d = n_done;
        @(negedge clk);
        auto_en = 1'b1;
        t = cyc + 7;
        wait_start("auto_latency", t);
        wait_done("auto_done", n0d + 2, 800);
        auto_en = 1'b0;
        check_msg("auto_msg1", "W 07:05:42");
        check_msg("auto_msg2", "W 07:05:42");
        idle(500);
        q.delete();
        n0s = n_start;
        idle(100);
        check("auto_off_starts", 32'(n_start - n0s), 32'd0);
        check("auto_off_busy",   32'(rep_busy),      32'd0);
        @(negedge clk);
        auto_en = 1'b1;
        t = cyc + 7;
        wait_start("auto_relatency", t);
        auto_en = 1'b0;
        idle(500);
        q.delete();

        // Reset asserted while the 4th byte is being launched.
        mode = 2'd2; dist_cm = 9'd300;
        pulse_req(t);
        seen = 0; k = 0;
        while (seen < 4 && k < 300) begin
            @(negedge clk);
            k++;
            if (tx_start) seen++;
        end
        check("rst_mid_seen", 32'(seen), 32'd4);
        #1 rst = 1'b0;
        #1;
        check("rst_mid_start", 32'(tx_start), 32'd0);
        check("rst_mid_busy",  32'(rep_busy), 32'd0);
        check("rst_mid_data",  32'(tx_data),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        q.delete();
        n0s = n_start; n0d = n_done;
        idle(300);
        check("rst_after_starts", 32'(n_start - n0s), 32'd0);
        check("rst_after_dones",  32'(n_done - n0d),  32'd0);
        dist_cm = 9'd42;
        send_and_check("rst_new", "D 042 cm");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_reporter.md
Name: uart_tx_reporter

Overview:
- Transmit-side counterpart of the UART command control unit: formats the currently selected display source as an ASCII text line and streams it byte-by-byte into the existing uart_tx.
- Sources: watch, stopwatch, SR04 distance, DHT11 temperature/humidity.
- Triggers: a single-cycle request pulse (button or UART command) or an internal periodic auto-report timer.
- Sits in Top alongside Top_cu; consumes the same mode-select switches.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz
- AUTO_MS, 1000, auto-report period in ms when auto_en=1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- report_req  in  1  single-cycle request pulse
- auto_en  in  1  enables periodic auto-report
- mode  in  2  source select: 0 watch, 1 stopwatch, 2 sr04, 3 dht11
- w_hour / w_min / w_sec  in  5/6/6  watch time
- s_min / s_sec / s_cc  in  6/6/7  stopwatch time, cc = 1/100 s
- dist_cm  in  9  SR04 distance in cm
- temp / humi  in  8/8  DHT11 integer values
- tx_busy  in  1  uart_tx busy
- tx_done  in  1  uart_tx byte-complete pulse
- tx_start  out  1  one-cycle start pulse to uart_tx
- tx_data  out  8  byte to send; stable from tx_start through tx_done
- rep_busy  out  1  high from request acceptance until the last tx_done
- rep_done  out  1  one-cycle pulse after the last byte's tx_done

Behaviour:
- Reset (rst=0, async): FSM=IDLE; tx_start=0, tx_data=8'h00, rep_busy=0, rep_done=0; char index=0; pending=0; auto counter=0.
- Auto timer:
  - Counts clk cycles only while auto_en=1; cleared while auto_en=0.
  - At CLK_HZ/1000*AUTO_MS-1 it wraps to 0 and issues an internal request pulse.
- Requests:
  - trig = report_req | auto pulse.
  - In IDLE, trig moves the FSM to LATCH.
  - In any other state, trig sets pending. Pending is a single bit: multiple requests coalesce into one.
  - On returning to IDLE with pending=1, pending clears and LATCH is entered next cycle.
- LATCH (1 cycle):
  - Snapshots mode and that mode's fields into registers; later input changes do not affect the message.
  - Sets rep_busy=1 and index=0.
- SEND: waits for tx_busy=0, then drives tx_start=1 for exactly one cycle with tx_data=char[index], and goes to WAIT.
- WAIT:
  - On tx_done: if index==len-1, go to IDLE, pulse rep_done for 1 cycle and drop rep_busy in the same cycle; else index+1 and go to SEND.
  - tx_done seen in any other state is ignored.
- Message formats (ASCII, every line terminated CR 8'h0D, LF 8'h0A):
  - mode 0: "W hh:mm:ss" + CRLF, len 12
  - mode 1: "S mm:ss.cc" + CRLF, len 12
  - mode 2: "D ddd cm" + CRLF, len 10; always 3 digits with leading zeros; max 511
  - mode 3: "T tt H hh" + CRLF, len 11
- Digit rules:
  - Two-digit fields print with a leading zero.
  - Any two-digit field value >99 saturates to "99" (temp, humi, s_cc, minutes/seconds >99 impossible but clamped uniformly).
  - Digit = 8'h30 + BCD.
- Latency: tx_start for the first byte is asserted 2 cycles after the trig cycle when tx_busy=0 (trig→LATCH→SEND).
- Reset mid-message: immediate abort, outputs to reset values; no partial resume.
- mode changes after LATCH: ignored until the next report.

Decomposition:
- Shared package: mode encodings (MODE_WATCH=0, MODE_SW=1, MODE_SR04=2, MODE_DHT=3), ASCII constants (CR, LF, SPACE, COLON, DOT, digit base 8'h30, letters W/S/D/T/H/c/m), message lengths per mode, FSM state encoding (IDLE, LATCH, SEND, WAIT).
- One sub-module: reporter_bin2bcd, a combinational 9-bit to 3-digit BCD converter (double-dabble), instantiated per latched field or time-shared through a field mux indexed by char index.
- Character selection is a combinational mux of (latched mode, index) in the top.

Test Plan:
- mode=0, w_hour=7, w_min=5, w_sec=42, report_req pulse, uart model with 10-cycle tx_done → bytes "W 07:05:42"\r\n (57 20 30 37 3A 30 35 3A 34 32 0D 0A), 12 tx_start pulses, rep_done once, first tx_start 2 cycles after req.
- mode=2, dist_cm=9 → "D 009 cm\r\n"; then dist_cm=511 → "D 511 cm\r\n"; change dist_cm mid-message → transmitted digits unchanged.
- mode=3, temp=200, humi=45 → "T 99 H 45\r\n" (saturation); mode=1, s_cc=120 → cc field "99".
- Three report_req pulses during an active message → exactly one extra message follows immediately; total 2 messages.
- auto_en=1 with CLK_HZ=1000, AUTO_MS=5 → reports begin every 5 cycles of timer period when idle; auto_en=0 → no further reports, counter cleared.
- Assert rst=0 at byte 4 of a message → tx_start, rep_busy drop asynchronously; after release no bytes sent until a new request.
